// File: rtl/tmr_regfile.sv
// Triple-modular-redundant register file: voted reads, a background scrubber
// that repairs copy mismatches, and fault-injection / error-count ports.
module tmr_regfile #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we3,
    input  logic [AW-1:0]    i_wa3,
    input  logic [WIDTH-1:0] i_wd3,
    input  logic [AW-1:0]    i_ra1,
    input  logic [AW-1:0]    i_ra2,
    output logic [WIDTH-1:0] o_rd1,
    output logic [WIDTH-1:0] o_rd2,
    input  logic             i_scrub_en,
    input  logic             i_inj_en,
    input  logic [1:0]       i_inj_copy,
    input  logic [AW-1:0]    i_inj_addr,
    input  logic [WIDTH-1:0] i_inj_mask,
    output logic             o_err_pulse,
    output logic             o_multi_err,
    output logic [CNT_W-1:0] o_err_count
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FIX   = 2'd2
    } t_state;

    function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    t_state             r_state;
    t_state             w_state_next;
    logic [AW-1:0]      r_scrub_addr;
    logic [WIDTH-1:0]   r_fix_val;
    logic               r_fix_multi;
    logic               r_err_pulse;
    logic               r_multi_err;
    logic [CNT_W-1:0]   r_err_count;

    logic [WIDTH-1:0]   w_rd1_c [3];
    logic [WIDTH-1:0]   w_rd2_c [3];
    logic [WIDTH-1:0]   w_sc_c  [3];
    logic [WIDTH-1:0]   w_sc_vote;
    logic               w_sc_mismatch;
    logic [1:0]         w_diff_cnt;
    logic               w_wr_en;
    logic               w_inj_any;
    logic               w_fix_apply;
    logic               w_addr_inc;
    logic               w_latch;

    assign w_wr_en   = i_we3 && !(ZERO_REG != 0 && i_wa3 == '0);
    assign w_inj_any = i_inj_en && (i_inj_copy != 2'd3);

    // A write or injection at the scrub address wins over the pending fix for all copies.
    assign w_fix_apply = (r_state == S_FIX) && i_scrub_en
                      && !(w_wr_en && i_wa3 == r_scrub_addr)
                      && !(w_inj_any && i_inj_addr == r_scrub_addr);

    for (genvar gi = 0; gi < 3; gi++) begin : g_copy
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic             w_inj_hit;

        assign w_inj_hit = w_inj_any && (i_inj_copy == 2'(gi));

        // Later assignments override earlier ones: write > injection > fix.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
            end else begin
                if (w_fix_apply) r_mem[r_scrub_addr] <= r_fix_val;
                if (w_inj_hit)   r_mem[i_inj_addr]   <= r_mem[i_inj_addr] ^ i_inj_mask;
                if (w_wr_en)     r_mem[i_wa3]        <= i_wd3;
            end
        end

        assign w_rd1_c[gi] = r_mem[i_ra1];
        assign w_rd2_c[gi] = r_mem[i_ra2];
        assign w_sc_c[gi]  = r_mem[r_scrub_addr];
    end

    assign o_rd1 = (ZERO_REG != 0 && i_ra1 == '0) ? '0 : vote3(w_rd1_c[0], w_rd1_c[1], w_rd1_c[2]);
    assign o_rd2 = (ZERO_REG != 0 && i_ra2 == '0) ? '0 : vote3(w_rd2_c[0], w_rd2_c[1], w_rd2_c[2]);

    assign w_sc_vote     = vote3(w_sc_c[0], w_sc_c[1], w_sc_c[2]);
    assign w_sc_mismatch = (w_sc_c[0] != w_sc_c[1]) || (w_sc_c[1] != w_sc_c[2]);
    assign w_diff_cnt    = {1'b0, w_sc_c[0] != w_sc_vote} + {1'b0, w_sc_c[1] != w_sc_vote}
                         + {1'b0, w_sc_c[2] != w_sc_vote};

    always_comb begin
        w_state_next = r_state;
        w_addr_inc   = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_scrub_en) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!i_scrub_en) begin
                    w_state_next = S_IDLE;
                end else if (w_sc_mismatch) begin
                    w_state_next = S_FIX;
                    w_latch      = 1'b1;
                end else begin
                    w_addr_inc = 1'b1;
                end
            end
            S_FIX: begin
                if (!i_scrub_en) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_CHECK;
                    w_addr_inc   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_scrub_addr <= '0;
            r_fix_val    <= '0;
            r_fix_multi  <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_multi_err  <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_err_pulse <= w_fix_apply;
            if (w_addr_inc) r_scrub_addr <= r_scrub_addr + 1'b1;
            if (w_latch) begin
                r_fix_val   <= w_sc_vote;
                r_fix_multi <= (w_diff_cnt >= 2'd2);
            end
            if (w_fix_apply) begin
                if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                r_multi_err <= r_multi_err | r_fix_multi;
            end
        end
    end

    assign o_err_pulse = r_err_pulse;
    assign o_multi_err = r_multi_err;
    assign o_err_count = r_err_count;
endmodule

// File: tb/tb_tmr_regfile.sv
// Bench for tmr_regfile: table-driven read/write vectors through a scoreboard
// queue, plus sequences for injection, scrubbing, write-vs-fix and reset mid-FIX.
module tb_tmr_regfile;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [AW-1:0]    ra1, ra2;
    logic [WIDTH-1:0] rd1, rd2;
    logic             scrub_en;
    logic             inj_en;
    logic [1:0]       inj_copy;
    logic [AW-1:0]    inj_addr;
    logic [WIDTH-1:0] inj_mask;
    logic             err_pulse, multi_err;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    tmr_regfile #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_we3(we3), .i_wa3(wa3), .i_wd3(wd3),
        .i_ra1(ra1), .i_ra2(ra2), .o_rd1(rd1), .o_rd2(rd2),
        .i_scrub_en(scrub_en), .i_inj_en(inj_en), .i_inj_copy(inj_copy),
        .i_inj_addr(inj_addr), .i_inj_mask(inj_mask),
        .o_err_pulse(err_pulse), .o_multi_err(multi_err), .o_err_count(err_count)
    );

    typedef struct {
        logic             we;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
        logic [AW-1:0]    ra1;
        logic [AW-1:0]    ra2;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_seen = 0;

    always @(negedge clk) if (err_pulse) pulse_seen <= pulse_seen + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        tick();
        we3 = 1'b0;
    endtask

    task automatic inject(input logic [1:0] c, input logic [AW-1:0] a, input logic [WIDTH-1:0] m);
        inj_en = 1'b1; inj_copy = c; inj_addr = a; inj_mask = m;
        tick();
        inj_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Returns at the negedge where the scrubber sits in FIX at address a.
    task automatic wait_fix(input string name, input logic [AW-1:0] a, input int bound);
        logic found;
        found = 1'b0;
        for (int k = 0; k < bound && !found; k++) begin
            if (32'(dut.r_state) == 2 && dut.r_scrub_addr == a) found = 1'b1;
            else tick();
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, wraps, prev_a, cur_a;
        exp_t e;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h00000001, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd31, 32'h12345678, 5'd0,  5'd31, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd5,  32'hA5A5A5A5, 5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
        vecs[5] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd5,  5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'h12345678, 32'h0};

        rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
        scrub_en = 1'b0; inj_en = 1'b0; inj_copy = 2'd3; inj_addr = '0; inj_mask = '0;
        tick(2);
        rst_n = 1'b1;
        tick();

        // Reads and writes, no bypass, register 0 hard-wired
        for (int i = 0; i < 7; i++) begin
            we3 = vecs[i].we; wa3 = vecs[i].wa; wd3 = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            sb.push_back('{vecs[i].e1, vecs[i].e2});
            #3;
            e = sb.pop_front();
            check($sformatf("vec%0d_rd1", i), rd1, e.rd1);
            check($sformatf("vec%0d_rd2", i), rd2, e.rd2);
            tick();
        end
        we3 = 1'b0;
        check("r0_copy0_unwritten", dut.g_copy[0].r_mem[0], 32'h0);

        // Single-copy fault, then scrub repairs it
        write_reg(5'd7, 32'h11223344);
        inject(2'd3, 5'd7, 32'h0000FFFF);
        check("inj_copy3_noeffect", dut.g_copy[1].r_mem[7], 32'h11223344);
        inject(2'd1, 5'd7, 32'h000000FF);
        ra1 = 5'd7; #1;
        check("r7_voted_after_inj", rd1, 32'h11223344);
        check("r7_copy1_corrupt", dut.g_copy[1].r_mem[7], 32'h112233BB);
        p0 = pulse_seen;
        scrub_en = 1'b1;
        tick(40);
        scrub_en = 1'b0;
        tick(2);
        check("t2_pulses", 32'(pulse_seen - p0), 32'd1);
        check("t2_err_count", 32'(err_count), 32'd1);
        check("t2_multi_err", 32'(multi_err), 32'd0);
        check("t2_r7_copy0", dut.g_copy[0].r_mem[7], 32'h11223344);
        check("t2_r7_copy1", dut.g_copy[1].r_mem[7], 32'h11223344);
        check("t2_r7_copy2", dut.g_copy[2].r_mem[7], 32'h11223344);

        // Two copies wrong in different bits: vote still right, flagged as multi
        write_reg(5'd3, 32'hCAFE0000);
        inject(2'd0, 5'd3, 32'h00000001);
        inject(2'd2, 5'd3, 32'h00000010);
        ra2 = 5'd3; #1;
        check("r3_voted_after_inj", rd2, 32'hCAFE0000);
        p0 = pulse_seen;
        scrub_en = 1'b1;
        tick(40);
        scrub_en = 1'b0;
        tick(2);
        check("t3_pulses", 32'(pulse_seen - p0), 32'd1);
        check("t3_err_count", 32'(err_count), 32'd2);
        check("t3_multi_err", 32'(multi_err), 32'd1);
        check("t3_r3_copy0", dut.g_copy[0].r_mem[3], 32'hCAFE0000);
        check("t3_r3_copy2", dut.g_copy[2].r_mem[3], 32'hCAFE0000);

        // Architectural write lands on the FIX edge at the same address
        do_reset();
        ra1 = 5'd5; #1;
        check("rst_rd_r5", rd1, 32'h0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_multi_err", 32'(multi_err), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_scrub_addr", 32'(dut.r_scrub_addr), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'd0);
        write_reg(5'd9, 32'h99999999);
        inject(2'd1, 5'd9, 32'h0000F0F0);
        p0 = pulse_seen;
        scrub_en = 1'b1;
        wait_fix("t4_reach_fix_r9", 5'd9, 50);
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h13579BDF;
        tick();
        we3 = 1'b0;
        tick(3);
        scrub_en = 1'b0;
        tick(2);
        ra1 = 5'd9; #1;
        check("t4_rd_r9", rd1, 32'h13579BDF);
        check("t4_r9_copy1", dut.g_copy[1].r_mem[9], 32'h13579BDF);
        check("t4_pulses", 32'(pulse_seen - p0), 32'd0);
        check("t4_err_count", 32'(err_count), 32'd0);

        // Clean sweep over more than two full passes: wraps, never pulses
        tick();
        p0 = pulse_seen;
        wraps = 0;
        prev_a = int'(dut.r_scrub_addr);
        scrub_en = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 5; k++) begin
            tick();
            cur_a = int'(dut.r_scrub_addr);
            if (prev_a == DEPTH - 1 && cur_a == 0) wraps++;
            prev_a = cur_a;
        end
        scrub_en = 1'b0;
        tick(2);
        check("t5_wraps_ge2", 32'(wraps >= 2), 32'd1);
        check("t5_pulses", 32'(pulse_seen - p0), 32'd0);

        // Reset asserted while the scrubber is in FIX
        write_reg(5'd18, 32'h0F0F0F0F);
        inject(2'd0, 5'd18, 32'h00000001);
        inject(2'd1, 5'd18, 32'h00000002);
        inject(2'd2, 5'd20, 32'h00000100);
        scrub_en = 1'b1;
        wait_fix("t6_reach_fix_r18", 5'd18, 80);
        tick();
        wait_fix("t6_reach_fix_r20", 5'd20, 10);
        check("t6_pre_err_count", 32'(err_count), 32'd1);
        check("t6_pre_multi_err", 32'(multi_err), 32'd1);
        rst_n = 1'b0;
        ra1 = 5'd20; ra2 = 5'd18;
        #1;
        check("t6_rst_err_count", 32'(err_count), 32'd0);
        check("t6_rst_multi_err", 32'(multi_err), 32'd0);
        check("t6_rst_err_pulse", 32'(err_pulse), 32'd0);
        check("t6_rst_rd_r20", rd1, 32'h0);
        check("t6_rst_rd_r18", rd2, 32'h0);
        check("t6_rst_r20_copy2", dut.g_copy[2].r_mem[20], 32'h0);
        check("t6_rst_state", 32'(dut.r_state), 32'd0);
        check("t6_rst_scrub_addr", 32'(dut.r_scrub_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart_state", 32'(dut.r_state), 32'd1);
        check("t6_restart_addr0", 32'(dut.r_scrub_addr), 32'd0);
        tick();
        check("t6_restart_addr1", 32'(dut.r_scrub_addr), 32'd1);
        p0 = pulse_seen;
        tick(40);
        scrub_en = 1'b0;
        tick(2);
        check("t6_post_pulses", 32'(pulse_seen - p0), 32'd0);
        check("t6_post_err_count", 32'(err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
